updown_counter_mod: RTL

Parametrised up/down modulo counter, the successor to the team's fixed 4-bit down counter. It adds:
- run-time direction and limit (count range 0..limit);
- synchronous parallel load;
- three end-of-range modes: wrap, saturate, one-shot.

It is used as a general timer/prescaler/event counter in sequential-circuit designs. It provides a combinational terminal-count flag and a registered one-cycle event pulse.

---
 rtl/counter_pkg.sv | 13 +
 rtl/updown_counter_mod.sv | 95 +++++++++
 2 files changed

// File: rtl/counter_pkg.sv
// counter_pkg
// Shared encodings for updown_counter_mod: end-of-range mode codes and
// the two FSM state codes. Mode 2'b11 is reserved and decodes as WRAP.
package counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

endpackage

// File: rtl/updown_counter_mod.sv
// updown_counter_mod
// Parametrised up/down modulo counter with run-time direction and limit,
// synchronous parallel load and three end-of-range modes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | normal stepping; tc and evt are live
// ST_DONE | one-shot finished; count frozen, done=1, enable ignored
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high reset
//   enable   count step permitted this cycle
//   dir      1 = count up, 0 = count down
//   load     synchronous parallel load (overrides enable and mode)
//   load_val value to load, clamped to limit
//   limit    upper bound of the count range 0..limit
//   mode     00 WRAP, 01 SATURATE, 10 ONESHOT, 11 treated as WRAP
//   count    current count
//   tc       combinational terminal-count flag
//   evt      registered one-cycle end-of-range pulse
//   done     one-shot completed
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             evt,
  output logic             done
);

  localparam logic [WIDTH-1:0] RST_COUNT = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] term;
  logic             evt_nxt;

  assign term = dir ? limit : '0;
  assign tc   = enable & (state == ST_RUN) & (count == term);
  assign done = (state == ST_DONE);

  always_comb begin
    count_nxt = count;
    evt_nxt   = 1'b0;
    state_nxt = state;
    if (load) begin
      count_nxt = (load_val < limit) ? load_val : limit;
      state_nxt = ST_RUN;
    end else if (state == ST_DONE) begin
      // Leaving one-shot mode releases the freeze without touching count.
      if (mode != MODE_ONESHOT) state_nxt = ST_RUN;
    end else if (enable) begin
      if (count > limit) begin
        // limit was lowered under us (or reset value exceeds it): snap back.
        count_nxt = limit;
      end else if (count != term) begin
        count_nxt = dir ? count + ONE : count - ONE;
      end else begin
        evt_nxt = 1'b1;
        case (mode)
          MODE_SAT:     count_nxt = count;
          MODE_ONESHOT: state_nxt = ST_DONE;
          default:      count_nxt = dir ? '0 : limit;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= RST_COUNT;
      evt   <= 1'b0;
      state <= ST_RUN;
    end else begin
      count <= count_nxt;
      evt   <= evt_nxt;
      state <= state_nxt;
    end
  end

endmodule
